// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared types, prices and limits for the vending dispense
//            scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } state_t;

    localparam logic [5:0] PRICE_A    = 6'd15;
    localparam logic [5:0] PRICE_B    = 6'd20;
    localparam logic [5:0] PRICE_C    = 6'd25;
    localparam logic [5:0] PRICE_D    = 6'd30;
    localparam logic [5:0] CREDIT_MAX = 6'd60;
    localparam int         TIMEOUT    = 200;

    // Last count value of the motor timeout; the counter starts at 0 in the
    // first DISPENSE cycle, so hitting this value means TIMEOUT cycles elapsed.
    localparam int         TMR_W      = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    function automatic logic [5:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = PRICE_A;
            2'd1:    price_of = PRICE_B;
            2'd2:    price_of = PRICE_C;
            default: price_of = PRICE_D;
        endcase
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        onehot_to_idx = 2'd0;
        if (oh[1]) onehot_to_idx = 2'd1;
        if (oh[2]) onehot_to_idx = 2'd2;
        if (oh[3]) onehot_to_idx = 2'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb4
// Purpose  : 4-way round-robin arbiter. The search starts at the requester
//            after the most recently granted one; pointer resets to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] eligible,
    input  logic       advance,
    output logic [3:0] grant
);

    logic [1:0] r_ptr;
    logic [1:0] w_cand;
    logic [1:0] w_win;
    logic       w_found;

    // Pick the first eligible requester at or after the pointer, wrapping.
    always_comb begin
        grant   = '0;
        w_win   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < 4; i++) begin
            w_cand = r_ptr + 2'(i);
            if (!w_found && eligible[w_cand]) begin
                w_found       = 1'b1;
                w_win         = w_cand;
                grant[w_cand] = 1'b1;
            end
        end
    end

    // Move the pointer past the winner only when the grant is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (advance && w_found) begin
            r_ptr <= w_win + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_dispense_sched.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_sched
// Purpose  : Coin credit accounting, round-robin product grant to a shared
//            dispense motor with timeout/refund, and coin change return.
// Revision : 1.0 - initial release
// ============================================================================
module vend_dispense_sched
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_5,
    input  logic       coin_10,
    input  logic [3:0] sel,
    input  logic       motor_done,
    output logic [3:0] disp,
    output logic       change_5,
    output logic       change_10,
    output logic       coin_reject,
    output logic [5:0] credit,
    output logic       busy,
    output logic       fault
);

    state_t           r_state, w_state_nxt;
    logic [5:0]       r_credit, w_credit_nxt;
    logic [3:0]       r_disp, w_disp_nxt;
    logic             r_change_5, w_change_5_nxt;
    logic             r_change_10, w_change_10_nxt;
    logic             r_coin_reject, w_coin_reject_nxt;
    logic             r_busy;
    logic             r_fault, w_fault_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic             r_gap, w_gap_nxt;

    logic [3:0]       w_eligible;
    logic [3:0]       w_grant;
    logic             w_coin_any;
    logic [6:0]       w_coin_sum;

    // A simultaneous 5 and 10 is a single 15-unit event.
    assign w_coin_any = coin_5 | coin_10;
    assign w_coin_sum = {1'b0, r_credit}
                      + (coin_5  ? 7'd5  : 7'd0)
                      + (coin_10 ? 7'd10 : 7'd0);

    // Eligibility uses the credit held before any same-cycle coin.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < 4; i++) begin
            w_eligible[i] = (r_state == ST_IDLE) && sel[i] && !r_fault
                         && (r_credit >= price_of(2'(i)));
        end
    end

    rr_arb4 u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (w_eligible),
        .advance  (|w_grant),
        .grant    (w_grant)
    );

    // Next-state and next-output decode for the scheduler.
    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_disp_nxt        = '0;
        w_change_5_nxt    = 1'b0;
        w_change_10_nxt   = 1'b0;
        w_coin_reject_nxt = 1'b0;
        w_fault_nxt       = r_fault;
        w_tmr_nxt         = r_tmr;
        w_idx_nxt         = r_idx;
        w_gap_nxt         = r_gap;

        case (r_state)
            ST_IDLE: begin
                if (w_coin_any) begin
                    if (w_coin_sum <= {1'b0, CREDIT_MAX}) begin
                        w_credit_nxt = w_coin_sum[5:0];
                    end else begin
                        w_coin_reject_nxt = 1'b1;
                    end
                end
                if (|w_grant) begin
                    w_disp_nxt  = w_grant;
                    w_idx_nxt   = onehot_to_idx(w_grant);
                    w_tmr_nxt   = '0;
                    w_state_nxt = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                w_coin_reject_nxt = w_coin_any;
                if (motor_done) begin
                    w_credit_nxt = r_credit - price_of(r_idx);
                    w_gap_nxt    = 1'b0;
                    w_state_nxt  = ST_CHANGE;
                end else if (r_tmr == TMR_LAST) begin
                    // Motor never finished: flag it and refund everything.
                    w_fault_nxt  = 1'b1;
                    w_gap_nxt    = 1'b0;
                    w_state_nxt  = ST_CHANGE;
                end else begin
                    w_tmr_nxt    = r_tmr + 1'b1;
                end
            end
            ST_CHANGE: begin
                w_coin_reject_nxt = w_coin_any;
                if (r_gap) begin
                    // Spacer cycle after each returned coin.
                    w_gap_nxt = 1'b0;
                    if (r_credit == 6'd0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_credit >= 6'd10) begin
                    w_change_10_nxt = 1'b1;
                    w_credit_nxt    = r_credit - 6'd10;
                    w_gap_nxt       = 1'b1;
                end else if (r_credit >= 6'd5) begin
                    w_change_5_nxt  = 1'b1;
                    w_credit_nxt    = r_credit - 6'd5;
                    w_gap_nxt       = 1'b1;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_credit      <= '0;
            r_disp        <= '0;
            r_change_5    <= 1'b0;
            r_change_10   <= 1'b0;
            r_coin_reject <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_tmr         <= '0;
            r_idx         <= '0;
            r_gap         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_disp        <= w_disp_nxt;
            r_change_5    <= w_change_5_nxt;
            r_change_10   <= w_change_10_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_fault       <= w_fault_nxt;
            r_tmr         <= w_tmr_nxt;
            r_idx         <= w_idx_nxt;
            r_gap         <= w_gap_nxt;
        end
    end

    assign disp        = r_disp;
    assign change_5    = r_change_5;
    assign change_10   = r_change_10;
    assign coin_reject = r_coin_reject;
    assign credit      = r_credit;
    assign busy        = r_busy;
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_dispense_sched
// Purpose  : Directed self-checking bench for vend_dispense_sched. Pulse
//            outputs are matched in order against an expected-event queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_5;
    logic       coin_10;
    logic [3:0] sel;
    logic       motor_done;
    logic [3:0] disp;
    logic       change_5;
    logic       change_10;
    logic       coin_reject;
    logic [5:0] credit;
    logic       busy;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;

    // Event codes: upper nibble kind, lower nibble payload.
    localparam logic [7:0] EV_C5   = 8'h20;
    localparam logic [7:0] EV_C10  = 8'h30;
    localparam logic [7:0] EV_REJ  = 8'h40;
    localparam logic [7:0] EV_NONE = 8'hFF;

    logic [7:0] exp_q[$];

    vend_dispense_sched dut (
        .clk         (clk),
        .rst         (rst),
        .coin_5      (coin_5),
        .coin_10     (coin_10),
        .sel         (sel),
        .motor_done  (motor_done),
        .disp        (disp),
        .change_5    (change_5),
        .change_10   (change_10),
        .coin_reject (coin_reject),
        .credit      (credit),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic take(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : EV_NONE;
        check(tag, obs, e);
    endtask

    // Pulse monitor: every output pulse must match the next queued event.
    always @(negedge clk) begin
        if (disp != 4'd0) take("ev_disp", {4'h1, disp});
        if (change_5)     take("ev_change5", EV_C5);
        if (change_10)    take("ev_change10", EV_C10);
        if (coin_reject)  take("ev_reject", EV_REJ);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic coin(input logic c5, input logic c10);
        coin_5  = c5;
        coin_10 = c10;
        tick();
        coin_5  = 1'b0;
        coin_10 = 1'b0;
    endtask

    task automatic pulse_done();
        motor_done = 1'b1;
        tick();
        motor_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40 && busy; k++) tick();
        check(tag, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; coin_5 = 1'b0; coin_10 = 1'b0; sel = 4'd0; motor_done = 1'b0;
        do_reset();
        check("rst_credit", {2'd0, credit}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_fault", {7'd0, fault}, 8'd0);
        check("rst_disp", {4'd0, disp}, 8'd0);

        // Buy A with 20, motor done 5 cycles after disp, get one 5 back.
        coin(1'b0, 1'b1);
        coin(1'b0, 1'b1);
        check("t1_credit20", {2'd0, credit}, 8'd20);
        exp_q.push_back(8'h11);
        exp_q.push_back(EV_C5);
        sel = 4'b0001;
        tick();
        sel = 4'b0000;
        check("t1_busy", {7'd0, busy}, 8'd1);
        repeat (4) tick();
        pulse_done();
        check("t1_credit5", {2'd0, credit}, 8'd5);
        wait_idle("t1_idle");
        check("t1_credit0", {2'd0, credit}, 8'd0);

        // Round robin A, B, C with all products requested.
        do_reset();
        repeat (3) coin(1'b0, 1'b1);
        exp_q.push_back(8'h11); exp_q.push_back(EV_C10); exp_q.push_back(EV_C5);
        sel = 4'b1111;
        tick();
        pulse_done();
        wait_idle("t2_idle_a");
        sel = 4'b0000;
        repeat (3) coin(1'b0, 1'b1);
        exp_q.push_back(8'h12); exp_q.push_back(EV_C10);
        sel = 4'b1111;
        tick();
        pulse_done();
        wait_idle("t2_idle_b");
        sel = 4'b0000;
        repeat (3) coin(1'b0, 1'b1);
        exp_q.push_back(8'h14); exp_q.push_back(EV_C5);
        sel = 4'b1111;
        tick();
        pulse_done();
        wait_idle("t2_idle_c");
        sel = 4'b0000;
        check("t2_credit0", {2'd0, credit}, 8'd0);

        // Credit ceiling.
        do_reset();
        repeat (5) coin(1'b0, 1'b1);
        coin(1'b1, 1'b0);
        check("t3_credit55", {2'd0, credit}, 8'd55);
        exp_q.push_back(EV_REJ);
        coin(1'b0, 1'b1);
        check("t3_rej_hold55", {2'd0, credit}, 8'd55);
        coin(1'b1, 1'b0);
        check("t3_credit60", {2'd0, credit}, 8'd60);
        exp_q.push_back(EV_REJ);
        coin(1'b1, 1'b0);
        check("t3_rej_hold60", {2'd0, credit}, 8'd60);

        // Simultaneous coins.
        do_reset();
        repeat (5) coin(1'b0, 1'b1);
        exp_q.push_back(EV_REJ);
        coin(1'b1, 1'b1);
        tick();
        check("t4_both_rej50", {2'd0, credit}, 8'd50);
        do_reset();
        repeat (4) coin(1'b0, 1'b1);
        coin(1'b1, 1'b1);
        check("t4_both_acc55", {2'd0, credit}, 8'd55);

        // Motor timeout with C at credit 25: fault, full refund.
        do_reset();
        coin(1'b0, 1'b1); coin(1'b0, 1'b1); coin(1'b1, 1'b0);
        exp_q.push_back(8'h14);
        exp_q.push_back(EV_REJ);
        exp_q.push_back(EV_C10); exp_q.push_back(EV_C10); exp_q.push_back(EV_C5);
        sel = 4'b0100;
        tick();
        sel = 4'b0000;
        coin(1'b0, 1'b1);
        check("t5_rej_busy_credit", {2'd0, credit}, 8'd25);
        repeat (198) tick();
        check("t5_nofault_199", {7'd0, fault}, 8'd0);
        tick();
        check("t5_fault_200", {7'd0, fault}, 8'd1);
        check("t5_refund25", {2'd0, credit}, 8'd25);
        wait_idle("t5_idle");
        check("t5_credit0", {2'd0, credit}, 8'd0);
        coin(1'b0, 1'b1);
        coin(1'b0, 1'b1);
        check("t5_fault_coin", {2'd0, credit}, 8'd20);
        sel = 4'b0001;
        repeat (4) tick();
        sel = 4'b0000;
        pulse_done();
        check("t5_no_grant", {7'd0, busy}, 8'd0);
        check("t5_ignore_done", {2'd0, credit}, 8'd20);
        check("t5_fault_sticky", {7'd0, fault}, 8'd1);

        // Reset during CHANGE at credit 20.
        do_reset();
        check("t6_fault_clr", {7'd0, fault}, 8'd0);
        repeat (3) coin(1'b0, 1'b1);
        coin(1'b1, 1'b0);
        exp_q.push_back(8'h11);
        sel = 4'b0001;
        tick();
        sel = 4'b0000;
        pulse_done();
        check("t6_credit20", {2'd0, credit}, 8'd20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_credit", {2'd0, credit}, 8'd0);
        check("t6_rst_busy", {7'd0, busy}, 8'd0);
        repeat (6) tick();

        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
